// File: rtl/feature_buf_port.sv
// -----------------------------------------------------------------------------
// feature_buf_port
// Initiator-side port controller for the ping-pong feature SRAM. Steers logical
// read/write requests to bank A or B according to buf_sel, returns read data
// with a fixed one-cycle latency, and flips buf_sel at layer boundaries once
// in-flight reads have drained. A bank is never read and written in one cycle.
//
// Optional feature macro: FEATURE_BUF_OOB_CHECK_EN
//   defined   : addresses >= DEPTH are handshaken but suppressed at the bank
//               (no write, read returns 0x00) and raise sticky o_err_oob.
//   undefined : addresses pass through unchecked, o_err_oob tied 0.
//
// Ports
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   i_swap_req / o_swap_done     bank flip request pulse / flip-effective pulse
//   o_buf_sel                    0: read A / write B, 1: read B / write A
//   i_load_mode                  writes target the read bank
//   i_rd_req_valid/o_rd_req_ready, i_rd_addr          read request
//   o_rd_resp_valid, o_rd_resp_data                   read response
//   i_wr_valid/o_wr_ready, i_wr_addr, i_wr_data       write request
//   o_wr_count                   writes accepted since last swap or reset
//   o_a_* / i_a_rdata            bank A SRAM port
//   o_b_* / i_b_rdata            bank B SRAM port
//   o_err_oob                    sticky out-of-range flag
// -----------------------------------------------------------------------------
module feature_buf_port #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 12000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_swap_req,
  output logic              o_swap_done,
  output logic              o_buf_sel,
  input  logic              i_load_mode,
  input  logic              i_rd_req_valid,
  output logic              o_rd_req_ready,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              o_rd_resp_valid,
  output logic [DATA_W-1:0] o_rd_resp_data,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic [ADDR_W:0]   o_wr_count,
  output logic              o_a_we,
  output logic [ADDR_W-1:0] o_a_waddr,
  output logic [DATA_W-1:0] o_a_wdata,
  output logic [ADDR_W-1:0] o_a_raddr,
  input  logic [DATA_W-1:0] i_a_rdata,
  output logic              o_b_we,
  output logic [ADDR_W-1:0] o_b_waddr,
  output logic [DATA_W-1:0] o_b_wdata,
  output logic [ADDR_W-1:0] o_b_raddr,
  input  logic [DATA_W-1:0] i_b_rdata,
  output logic              o_err_oob
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Elaboration guard: the bank must be addressable with ADDR_W bits.
  if (DEPTH > (32'd1 << ADDR_W)) begin : g_depth_chk
    $error("feature_buf_port: DEPTH does not fit in ADDR_W address bits");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLIP  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_buf_sel;
  logic              r_rd_pend;
  logic              r_rd_tag;
  logic              r_rd_oob;
  logic [CNT_W-1:0]  r_wr_count;

  logic              w_idle;
  logic              w_rd_acc;
  logic              w_wr_acc;
  logic              w_rd_oob;
  logic              w_wr_oob;
  logic              w_wr_bank;
  logic              w_flip_entry;

  // Range check on incoming addresses (only with the OOB feature).
`ifdef FEATURE_BUF_OOB_CHECK_EN
  localparam logic [CNT_W-1:0] DEPTH_L = CNT_W'(DEPTH);
  logic r_err_oob;

  assign w_rd_oob = ({1'b0, i_rd_addr} >= DEPTH_L);
  assign w_wr_oob = ({1'b0, i_wr_addr} >= DEPTH_L);

  // Sticky error: set by any handshaken out-of-range request.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_err_oob <= 1'b0;
    end else if ((w_rd_acc && w_rd_oob) || (w_wr_acc && w_wr_oob)) begin
      r_err_oob <= 1'b1;
    end
  end

  assign o_err_oob = r_err_oob;
`else
  assign w_rd_oob  = 1'b0;
  assign w_wr_oob  = 1'b0;
  assign o_err_oob = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: drain waits for the last read response before flipping.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (i_swap_req) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (!r_rd_pend) w_state_nxt = ST_FLIP;
      ST_FLIP:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: requests only in IDLE; a shared-bank write blocks the read.
  always_comb begin
    w_idle         = 1'b0;
    o_swap_done    = 1'b0;
    o_wr_ready     = 1'b0;
    o_rd_req_ready = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_idle         = 1'b1;
        o_wr_ready     = 1'b1;
        o_rd_req_ready = !(i_load_mode && i_wr_valid);
      end
      ST_FLIP:  o_swap_done = 1'b1;
      default: ;
    endcase
  end

  assign w_rd_acc     = i_rd_req_valid && o_rd_req_ready;
  assign w_wr_acc     = i_wr_valid && o_wr_ready;
  // Write bank: opposite of read bank, or the read bank itself during load.
  assign w_wr_bank    = i_load_mode ? r_buf_sel : ~r_buf_sel;
  assign w_flip_entry = (r_state == ST_DRAIN) && (w_state_nxt == ST_FLIP);

  // Bank select, response tag and write counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_buf_sel  <= 1'b0;
      r_rd_pend  <= 1'b0;
      r_rd_tag   <= 1'b0;
      r_rd_oob   <= 1'b0;
      r_wr_count <= '0;
    end else begin
      r_rd_pend <= w_rd_acc;
      if (w_rd_acc) begin
        r_rd_tag <= r_buf_sel;
        r_rd_oob <= w_rd_oob;
      end
      if (w_flip_entry) begin
        r_buf_sel <= ~r_buf_sel;
      end
      if (w_flip_entry) begin
        r_wr_count <= '0;
      end else if (w_wr_acc && (r_wr_count != CNT_MAX)) begin
        r_wr_count <= r_wr_count + CNT_W'(1);
      end
    end
  end

  // Bank port steering; idle ports are held at zero.
  always_comb begin
    o_a_we    = 1'b0;
    o_a_waddr = '0;
    o_a_wdata = '0;
    o_a_raddr = '0;
    o_b_we    = 1'b0;
    o_b_waddr = '0;
    o_b_wdata = '0;
    o_b_raddr = '0;
    if (w_rd_acc && !w_rd_oob) begin
      if (r_buf_sel) o_b_raddr = i_rd_addr;
      else           o_a_raddr = i_rd_addr;
    end
    if (w_wr_acc && !w_wr_oob) begin
      if (w_wr_bank) begin
        o_b_we    = 1'b1;
        o_b_waddr = i_wr_addr;
        o_b_wdata = i_wr_data;
      end else begin
        o_a_we    = 1'b1;
        o_a_waddr = i_wr_addr;
        o_a_wdata = i_wr_data;
      end
    end
  end

  // Response mux uses the registered tag so load_mode changes cannot steer it.
  assign o_rd_resp_valid = r_rd_pend;
  assign o_rd_resp_data  = (r_rd_pend && !r_rd_oob) ?
                           (r_rd_tag ? i_b_rdata : i_a_rdata) : '0;
  assign o_buf_sel       = r_buf_sel;
  assign o_wr_count      = r_wr_count;

endmodule

// File: tb/tb_feature_buf_port.sv
module tb_feature_buf_port;
  localparam int unsigned ADDR_W = 14;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 12000;
  localparam int unsigned CMAX   = (1 << (ADDR_W + 1)) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              swap_req, swap_done, buf_sel, load_mode;
  logic              rd_req_valid, rd_req_ready, rd_resp_valid;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_resp_data;
  logic              wr_valid, wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W:0]   wr_count;
  logic              a_we, b_we, err_oob;
  logic [ADDR_W-1:0] a_waddr, a_raddr, b_waddr, b_raddr;
  logic [DATA_W-1:0] a_wdata, a_rdata, b_wdata, b_rdata;

  always #5 clk = ~clk;

  feature_buf_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_swap_req(swap_req), .o_swap_done(swap_done), .o_buf_sel(buf_sel),
    .i_load_mode(load_mode),
    .i_rd_req_valid(rd_req_valid), .o_rd_req_ready(rd_req_ready), .i_rd_addr(rd_addr),
    .o_rd_resp_valid(rd_resp_valid), .o_rd_resp_data(rd_resp_data),
    .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .o_wr_count(wr_count),
    .o_a_we(a_we), .o_a_waddr(a_waddr), .o_a_wdata(a_wdata), .o_a_raddr(a_raddr), .i_a_rdata(a_rdata),
    .o_b_we(b_we), .o_b_waddr(b_waddr), .o_b_wdata(b_wdata), .o_b_raddr(b_raddr), .i_b_rdata(b_rdata),
    .o_err_oob(err_oob)
  );

  // Synchronous-read SRAM banks (unwritten locations read as zero).
  logic [7:0] sram_a [int];
  logic [7:0] sram_b [int];
  always @(posedge clk) begin
    a_rdata <= sram_a.exists(int'(a_raddr)) ? sram_a[int'(a_raddr)] : 8'h00;
    b_rdata <= sram_b.exists(int'(b_raddr)) ? sram_b[int'(b_raddr)] : 8'h00;
    if (a_we) sram_a[int'(a_waddr)] = a_wdata;
    if (b_we) sram_b[int'(b_waddr)] = b_wdata;
  end

  // Reference model: logical bank contents plus timestamps of the swap.
  logic [7:0]  ref_a [int];
  logic [7:0]  ref_b [int];
  bit          m_sel, m_pend, m_err;
  logic [7:0]  m_pend_data;
  int          m_busy_until, m_flip;
  int unsigned m_wcnt;
  int          cyc;
  int          errors, checks;

  logic        o_rd_ready, o_a_we, o_b_we, o_swap_done, o_buf_sel, o_valid;
  logic [ADDR_W-1:0] o_a_raddr, o_b_raddr, o_a_waddr;
  logic [7:0]  o_data;
  logic [ADDR_W:0] o_wcnt;

  function automatic logic [7:0] ref_rd(input bit bank, input int addr);
    if (bank) return ref_b.exists(addr) ? ref_b[addr] : 8'h00;
    return ref_a.exists(addr) ? ref_a[addr] : 8'h00;
  endfunction

  function automatic bit is_oob(input int addr);
`ifdef FEATURE_BUF_OOB_CHECK_EN
    return addr >= int'(DEPTH);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_sel = 0; m_pend = 0; m_err = 0; m_pend_data = 8'h00;
    m_busy_until = -1; m_flip = -1; m_wcnt = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: drive, predict, check mid-cycle, advance the model.
  task automatic step(input bit rv, input int ra, input bit wv, input int wa,
                      input logic [7:0] wd, input bit lm, input bit sr);
    bit idle, rrdy, racc, wacc, rbank, wbank, roob, woob;
    bit ea_we, eb_we;
    logic [7:0] nd;
    rd_req_valid = rv; rd_addr = ADDR_W'(ra);
    wr_valid = wv; wr_addr = ADDR_W'(wa); wr_data = wd;
    load_mode = lm; swap_req = sr;
    if (cyc == m_flip) begin
      m_sel = !m_sel;
      m_wcnt = 0;
    end
    idle  = cyc > m_busy_until;
    rrdy  = idle && !(lm && wv);
    racc  = rv && rrdy;
    wacc  = wv && idle;
    rbank = m_sel;
    wbank = lm ? m_sel : !m_sel;
    roob  = is_oob(ra);
    woob  = is_oob(wa);
    ea_we = wacc && !woob && !wbank;
    eb_we = wacc && !woob && wbank;
    nd    = (racc && !roob) ? ref_rd(rbank, ra) : 8'h00;
    #4;
    o_rd_ready = rd_req_ready; o_a_we = a_we; o_b_we = b_we;
    o_a_raddr = a_raddr; o_b_raddr = b_raddr; o_a_waddr = a_waddr;
    o_swap_done = swap_done; o_buf_sel = buf_sel; o_valid = rd_resp_valid;
    o_data = rd_resp_data; o_wcnt = wr_count;
    chk("rd_req_ready", 32'(rd_req_ready), 32'(rrdy));
    chk("wr_ready",     32'(wr_ready), 32'(idle));
    chk("a_we",         32'(a_we), 32'(ea_we));
    chk("a_waddr",      32'(a_waddr), ea_we ? 32'(wa) : 32'd0);
    chk("a_wdata",      32'(a_wdata), ea_we ? 32'(wd) : 32'd0);
    chk("a_raddr",      32'(a_raddr), (racc && !roob && !rbank) ? 32'(ra) : 32'd0);
    chk("b_we",         32'(b_we), 32'(eb_we));
    chk("b_waddr",      32'(b_waddr), eb_we ? 32'(wa) : 32'd0);
    chk("b_wdata",      32'(b_wdata), eb_we ? 32'(wd) : 32'd0);
    chk("b_raddr",      32'(b_raddr), (racc && !roob && rbank) ? 32'(ra) : 32'd0);
    chk("swap_done",    32'(swap_done), 32'(cyc == m_flip));
    chk("buf_sel",      32'(buf_sel), 32'(m_sel));
    chk("rd_resp_valid", 32'(rd_resp_valid), 32'(m_pend));
    chk("rd_resp_data", 32'(rd_resp_data), m_pend ? 32'(m_pend_data) : 32'd0);
    chk("wr_count",     32'(wr_count), m_wcnt);
    chk("err_oob",      32'(err_oob), 32'(m_err));
    @(posedge clk);
    if (wacc && !woob) begin
      if (wbank) ref_b[wa] = wd;
      else       ref_a[wa] = wd;
    end
    if (wacc && m_wcnt < CMAX) m_wcnt++;
    if (sr && idle) begin
      m_flip = cyc + 2 + (racc ? 1 : 0);
      m_busy_until = m_flip;
    end
    m_err = m_err || (racc && roob) || (wacc && woob);
    m_pend = racc;
    m_pend_data = nd;
    #1;
    cyc++;
  endtask

  task automatic step_idle();
    step(0, 0, 0, 0, 8'h00, 0, 0);
  endtask

  task automatic do_swap();
    step(0, 0, 0, 0, 8'h00, 0, 1);
    step_idle();
    step_idle();
  endtask

  function automatic int rand_addr();
    if ($urandom_range(0, 15) == 0) return int'(DEPTH) + int'($urandom_range(0, 7));
    return int'($urandom_range(0, 31));
  endfunction

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_buf_sel"}, 32'(buf_sel), 0);
    chk({pfx, "_swap_done"}, 32'(swap_done), 0);
    chk({pfx, "_resp_valid"}, 32'(rd_resp_valid), 0);
    chk({pfx, "_resp_data"}, 32'(rd_resp_data), 0);
    chk({pfx, "_wr_count"}, 32'(wr_count), 0);
    chk({pfx, "_err_oob"}, 32'(err_oob), 0);
    chk({pfx, "_a_port"}, {a_we, a_waddr, a_wdata}, 0);
    chk({pfx, "_a_raddr"}, 32'(a_raddr), 0);
    chk({pfx, "_b_port"}, {b_we, b_waddr, b_wdata}, 0);
    chk({pfx, "_b_raddr"}, 32'(b_raddr), 0);
  endtask

  initial begin
    errors = 0; checks = 0; cyc = 0;
    model_reset();
    rst = 1'b1;
    swap_req = 0; load_mode = 0; rd_req_valid = 0; rd_addr = '0;
    wr_valid = 0; wr_addr = '0; wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Write to B at buf_sel=0, swap, read back from B.
    step(0, 0, 1, 5, 8'h3C, 0, 0);
    chk("tp1_b_we", 32'(o_b_we), 1);
    chk("tp1_a_we", 32'(o_a_we), 0);
    step(0, 0, 0, 0, 8'h00, 0, 1);
    step_idle();
    chk("tp1_drain_swap_done", 32'(o_swap_done), 0);
    step_idle();
    chk("tp1_swap_done", 32'(o_swap_done), 1);
    chk("tp1_buf_sel", 32'(o_buf_sel), 1);
    step(1, 5, 0, 0, 8'h00, 0, 0);
    chk("tp1_b_raddr", 32'(o_b_raddr), 5);
    step_idle();
    chk("tp1_resp_valid", 32'(o_valid), 1);
    chk("tp1_resp_data", 32'(o_data), 32'h3C);

    // Read accepted together with swap_req: old-bank data, one extra drain cycle.
    step(1, 5, 0, 0, 8'h00, 0, 1);
    step_idle();
    chk("tp3_resp_data", 32'(o_data), 32'h3C);
    chk("tp3_buf_sel_n1", 32'(o_buf_sel), 1);
    step_idle();
    chk("tp3_swap_done_n2", 32'(o_swap_done), 0);
    chk("tp3_buf_sel_n2", 32'(o_buf_sel), 1);
    step_idle();
    chk("tp3_swap_done_n3", 32'(o_swap_done), 1);
    chk("tp3_buf_sel_n3", 32'(o_buf_sel), 0);

    // load_mode write wins the shared read bank.
    step(1, 9, 1, 7, 8'h5A, 1, 0);
    chk("tp2_rd_ready", 32'(o_rd_ready), 0);
    chk("tp2_a_we", 32'(o_a_we), 1);
    chk("tp2_b_we", 32'(o_b_we), 0);
    chk("tp2_a_raddr", 32'(o_a_raddr), 0);
    chk("tp2_a_waddr", 32'(o_a_waddr), 7);
    step(1, 7, 0, 0, 8'h00, 0, 0);
    step_idle();
    chk("tp2_readback", 32'(o_data), 32'h5A);

    // 11,999 writes, then swap clears the count.
    do_swap();
    for (int i = 0; i < 11999; i++) step(0, 0, 1, i, 8'($urandom), 0, 0);
    step(0, 0, 0, 0, 8'h00, 0, 1);
    chk("tp4_count_before", 32'(o_wcnt), 11999);
    step_idle();
    step_idle();
    chk("tp4_swap_done", 32'(o_swap_done), 1);
    step_idle();
    chk("tp4_count_after", 32'(o_wcnt), 0);

    // Counter saturation.
    for (int i = 0; i < int'(CMAX) + 3; i++) step(0, 0, 1, i % 32, 8'($urandom), 0, 0);
    step_idle();
    chk("sat_count", 32'(o_wcnt), CMAX);
    do_swap();

    // Out-of-range accesses.
    step(0, 0, 1, 12000, 8'hA5, 0, 0);
`ifdef FEATURE_BUF_OOB_CHECK_EN
    chk("oob_a_we", 32'(o_a_we), 0);
    chk("oob_b_we", 32'(o_b_we), 0);
    step(1, 12001, 0, 0, 8'h00, 0, 0);
    chk("oob_err_set", 32'(err_oob), 1);
    step_idle();
    chk("oob_rd_valid", 32'(o_valid), 1);
    chk("oob_rd_data", 32'(o_data), 0);
`else
    step(1, 12001, 0, 0, 8'h00, 0, 0);
    step_idle();
    chk("oob_err_tied", 32'(err_oob), 0);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      step(1'($urandom), rand_addr(), 1'($urandom), rand_addr(), 8'($urandom),
           $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
    end
    repeat (4) step_idle();

    // Reset in DRAIN with a response pending.
    if (!m_sel) do_swap();
    step(0, 0, 1, 3, 8'h11, 0, 0);
    step(1, 3, 0, 0, 8'h00, 0, 1);
    rst = 1'b1;
    rd_req_valid = 0; wr_valid = 0; swap_req = 0; load_mode = 0;
    #2;
    chk_reset_outputs("mid_drain_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    step_idle();
    chk("post_rst_swap_done", 32'(o_swap_done), 0);
    for (int i = 0; i < 60; i++) begin
      step(1'($urandom), rand_addr(), 1'($urandom), rand_addr(), 8'($urandom),
           $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
